// File: rtl/game_pkg.sv
// Shared types and constants for the Pong game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    PAUSED = 3'd4,
    OVER   = 3'd5
  } game_state_t;

  localparam int SERVE_DELAY_DEFAULT = 25_000_000;

  typedef struct packed {
    logic ball_reset;
    logic ball_en;
    logic paddle_en;
  } drive_t;

  // Ball/paddle enables that belong to each state; loaded together with the state.
  function automatic drive_t state_drive(game_state_t s);
    drive_t d;
    d = '{ball_reset: 1'b1, ball_en: 1'b0, paddle_en: 1'b0};
    case (s)
      SERVE:   d = '{ball_reset: 1'b1, ball_en: 1'b0, paddle_en: 1'b1};
      PLAY:    d = '{ball_reset: 1'b0, ball_en: 1'b1, paddle_en: 1'b1};
      PAUSED:  d = '{ball_reset: 1'b0, ball_en: 1'b0, paddle_en: 1'b0};
      default: d = '{ball_reset: 1'b1, ball_en: 1'b0, paddle_en: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/game_ctrl_edge_detect.sv
// Rising-edge detector for an already synchronised button level.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic q;

  // History resets high so a button held through reset yields no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RESET_VAL;
    else       q <= level;
  end

  assign rise = level & ~q;

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer: Moore FSM with one shared down-counter for serve delay and point wait.
// Optional macro GAME_CTRL_PAUSE_EN adds the PAUSED state and pause edge detection.
module game_ctrl
  import game_pkg::*;
#(
  parameter int SERVE_DELAY = SERVE_DELAY_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       score_left,
  input  logic       score_right,
  input  logic       game_over,
  output logic       ball_reset,
  output logic       ball_en,
  output logic       paddle_en,
  output logic       serve_dir,
  output logic       score_clear,
  output logic [2:0] state
);

  localparam int CW = $clog2(SERVE_DELAY);
  localparam logic [CW-1:0] CNT_SERVE = CW'(SERVE_DELAY - 1);
  localparam logic [CW-1:0] CNT_POINT = CW'(1);

  game_state_t   cur;
  drive_t        drv;
  logic [CW-1:0] cnt;
  logic          start_rise;
  logic          pause_rise;

  edge_detect #(.RESET_VAL(1'b1)) u_start_edge (
    .clk   (clk),
    .reset (reset),
    .level (start),
    .rise  (start_rise)
  );

`ifdef GAME_CTRL_PAUSE_EN
  edge_detect #(.RESET_VAL(1'b1)) u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .level (pause),
    .rise  (pause_rise)
  );
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_rise   = 1'b0;
`endif

  // Enables are loaded alongside every state change so all outputs stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      drv         <= state_drive(IDLE);
      cnt         <= '0;
      serve_dir   <= 1'b1;
      score_clear <= 1'b0;
    end else begin
      score_clear <= 1'b0;
      case (cur)
        IDLE, OVER: begin
          if (start_rise) begin
            cur         <= SERVE;
            drv         <= state_drive(SERVE);
            cnt         <= CNT_SERVE;
            score_clear <= 1'b1;
            serve_dir   <= 1'b1;
          end
        end
        SERVE: begin
          if (cnt == '0) begin
            cur <= PLAY;
            drv <= state_drive(PLAY);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PLAY: begin
          // Left beats right, and any score beats a pause edge in the same cycle.
          if (score_left) begin
            cur       <= POINT;
            drv       <= state_drive(POINT);
            cnt       <= CNT_POINT;
            serve_dir <= 1'b1;
          end else if (score_right) begin
            cur       <= POINT;
            drv       <= state_drive(POINT);
            cnt       <= CNT_POINT;
            serve_dir <= 1'b0;
          end else if (pause_rise) begin
            cur <= PAUSED;
            drv <= state_drive(PAUSED);
          end
        end
        POINT: begin
          if (cnt == '0) begin
            if (game_over) begin
              cur <= OVER;
              drv <= state_drive(OVER);
            end else begin
              cur <= SERVE;
              drv <= state_drive(SERVE);
              cnt <= CNT_SERVE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef GAME_CTRL_PAUSE_EN
        PAUSED: begin
          if (pause_rise) begin
            cur <= PLAY;
            drv <= state_drive(PLAY);
          end
        end
`endif
        default: begin
          cur <= IDLE;
          drv <= state_drive(IDLE);
        end
      endcase
    end
  end

  assign ball_reset = drv.ball_reset;
  assign ball_en    = drv.ball_en;
  assign paddle_en  = drv.paddle_en;
  assign state      = cur;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl with a cycle-age reference model of the game rules.
module tb_game_ctrl;

  localparam int SD = 4;

  localparam logic [2:0] M_IDLE   = 3'd0;
  localparam logic [2:0] M_SERVE  = 3'd1;
  localparam logic [2:0] M_PLAY   = 3'd2;
  localparam logic [2:0] M_POINT  = 3'd3;
  localparam logic [2:0] M_PAUSED = 3'd4;
  localparam logic [2:0] M_OVER   = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pause;
  logic       score_left;
  logic       score_right;
  logic       game_over;
  logic       ball_reset;
  logic       ball_en;
  logic       paddle_en;
  logic       serve_dir;
  logic       score_clear;
  logic [2:0] state;
  logic [7:0] dut_vec;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  logic [2:0] m_phase;
  int         m_age;
  logic       m_dir;
  logic       m_clear;
  logic       m_prev_start;
  logic       m_prev_pause;

  always #5 clk = ~clk;

  game_ctrl #(.SERVE_DELAY(SD)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .ball_reset  (ball_reset),
    .ball_en     (ball_en),
    .paddle_en   (paddle_en),
    .serve_dir   (serve_dir),
    .score_clear (score_clear),
    .state       (state)
  );

  assign dut_vec = {state, ball_reset, ball_en, paddle_en, serve_dir, score_clear};

  function automatic logic [7:0] model_vec();
    logic [2:0] en;
    case (m_phase)
      M_SERVE:  en = 3'b101;
      M_PLAY:   en = 3'b011;
      M_PAUSED: en = 3'b000;
      default:  en = 3'b100;
    endcase
    return {m_phase, en, m_dir, m_clear};
  endfunction

  task automatic model_reset();
    m_phase      = M_IDLE;
    m_age        = 0;
    m_dir        = 1'b1;
    m_clear      = 1'b0;
    m_prev_start = 1'b1;
    m_prev_pause = 1'b1;
  endtask

  task automatic enter(input logic [2:0] p);
    m_phase = p;
    m_age   = 0;
  endtask

  // One clock edge of the game rules: phases are timed by how many cycles they have lasted.
  task automatic model_step();
    logic st_edge;
    logic pa_edge;
    st_edge      = start & ~m_prev_start;
    pa_edge      = pause & ~m_prev_pause;
    m_prev_start = start;
    m_prev_pause = pause;
    m_clear      = 1'b0;
    m_age++;
    case (m_phase)
      M_IDLE, M_OVER: if (st_edge) begin
        enter(M_SERVE);
        m_clear = 1'b1;
        m_dir   = 1'b1;
      end
      M_SERVE: if (m_age == SD) enter(M_PLAY);
      M_PLAY: begin
        if (score_left) begin
          enter(M_POINT);
          m_dir = 1'b1;
        end else if (score_right) begin
          enter(M_POINT);
          m_dir = 1'b0;
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (pa_edge) enter(M_PAUSED);
`endif
      end
      M_POINT: if (m_age == 2) enter(game_over ? M_OVER : M_SERVE);
      M_PAUSED: if (pa_edge) enter(M_PLAY);
      default: enter(M_IDLE);
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s @%0t: got {state,brst,ben,pen,dir,clr}=%b expected %b", name, $time, got, want);
    end
  endtask

  // Drives inputs for n cycles, advancing the model and queueing the expected outputs after each edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic pa,
                               input logic sl, input logic sr, input logic go, input int n);
    reset       = rst;
    start       = st;
    pause       = pa;
    score_left  = sl;
    score_right = sr;
    game_over   = go;
    if (rst) model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      exp_q.push_back(model_vec());
      @(negedge clk);
      #2;
    end
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("scoreboard", dut_vec, e);
      end
    end
  end

  initial begin : driver
    logic st, pa, sl, sr, go, rs;
    reset = 1'b1; start = 1'b1; pause = 1'b0;
    score_left = 1'b0; score_right = 1'b0; game_over = 1'b0;
    model_reset();
    @(negedge clk);
    #2;

    applyStimulus(1, 1, 0, 0, 0, 0, 3);
    applyStimulus(0, 1, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 6);
    applyStimulus(0, 1, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 9);
    applyStimulus(0, 1, 0, 1, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 7);
    applyStimulus(0, 1, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 3);
    applyStimulus(0, 1, 1, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0, 0, 2);
    applyStimulus(0, 1, 1, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 8);

    applyStimulus(1, 0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 2);
    reset = 1'b1;
    model_reset();
    #1;
    checkOutput("async_reset_in_serve", dut_vec, model_vec());
    applyStimulus(1, 1, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 2);

    st = 1'b0;
    pa = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) st = ~st;
      if ($urandom_range(0, 4) == 0) pa = ~pa;
      sl = ($urandom_range(0, 9) == 0);
      sr = ($urandom_range(0, 9) == 0);
      go = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 149) == 0);
      applyStimulus(rs, st, pa, sl, sr, go, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 2);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level Pong game sequencer between the player buttons, the `ball` datapath and the `score` counter. It registers start/pause requests and the ball's point pulses, then drives the ball and paddle enables, the serve direction and the score clear. It is a Moore FSM with one shared down-counter, timing the serve delay and the wait for the score update.

## Interface
Parameters:
- `SERVE_DELAY`, default 25_000_000: cycles the ball is held at centre before each serve (1 s at 25 MHz). Legal range is 2 to 2^26-1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  start button level, already synchronised. Only its rising edge acts.
- `pause`  in  1  pause button level, already synchronised. Its rising edge toggles pause.
- `score_left`  in  1  one-cycle pulse from `ball`: the left player won a point.
- `score_right`  in  1  one-cycle pulse from `ball`: the right player won a point.
- `game_over`  in  1  level from `score`. Valid one cycle after a score pulse.
- `ball_reset`  out  1  holds the ball at centre.
- `ball_en`  out  1  ball may move.
- `paddle_en`  out  1  paddle inputs accepted.
- `serve_dir`  out  1  1 = serve toward right, 0 = serve toward left.
- `score_clear`  out  1  one-cycle pulse that zeroes `score`.
- `state`  out  3  current state encoding, for debug and display.

## Operation
States (`game_state_t`): IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, OVER=5.

Outputs per state:
- IDLE: ball_reset=1, ball_en=0, paddle_en=0.
- SERVE: ball_reset=1, ball_en=0, paddle_en=1.
- PLAY: ball_reset=0, ball_en=1, paddle_en=1.
- POINT: ball_reset=1, ball_en=0, paddle_en=0.
- PAUSED: ball_reset=0, ball_en=0, paddle_en=0. The ball freezes in place.
- OVER: ball_reset=1, ball_en=0, paddle_en=0.

Transitions:
- IDLE or OVER, on a start edge: go to SERVE. Load `cnt`=SERVE_DELAY-1. Pulse score_clear. Set serve_dir=1.
- SERVE: decrement `cnt` each cycle. When `cnt`==0, go to PLAY.
- PLAY, on score_left: go to POINT, load `cnt`=1, set serve_dir=1 (serve toward the player who conceded).
- PLAY, on score_right: go to POINT, load `cnt`=1, set serve_dir=0.
- PLAY, on a pause edge: go to PAUSED.
- PAUSED, on a pause edge: return to PLAY. `cnt` and serve_dir are unchanged.
- POINT: decrement `cnt`. When `cnt`==0, sample game_over. If 1, go to OVER. If 0, go to SERVE and load `cnt`=SERVE_DELAY-1.

Boundary rules:
- score_left and score_right in the same cycle: score_left wins.
- Score pulses outside PLAY are ignored.
- Start edges are ignored in SERVE, PLAY, POINT and PAUSED.
- Pause edges are ignored outside PLAY and PAUSED.
- A score pulse and a pause edge in the same PLAY cycle: the score wins.
- Reset asserted mid-game returns to IDLE immediately.
- The edge-detect history registers reset to 1. A button held through reset therefore produces no edge.

## Timing
- All outputs are registered and change only on the `clk` edge, except during asynchronous reset.
- Reset values: state=IDLE, ball_reset=1, ball_en=0, paddle_en=0, serve_dir=1, score_clear=0, `cnt`=0.
- Start-edge latency: score_clear is high for exactly the one cycle after the edge that sampled the start rising edge. SERVE is entered on that same edge.
- ball_en rises exactly SERVE_DELAY cycles after SERVE is entered.
- POINT lasts exactly 2 cycles. game_over is sampled on the second edge.
- `cnt` width is $clog2(SERVE_DELAY). Counts never wrap, because every state that uses `cnt` exits at 0.

## Configuration
- Macro `GAME_CTRL_PAUSE_EN`.
- Defined: PAUSED state and pause edge detection are present, as described above.
- Undefined: the `pause` port remains but is ignored, and PAUSED is unreachable. The encoding value 4 is still reserved.

## Structure
- `game_pkg` holds `game_state_t` (3-bit enum with the encodings above) and the default SERVE_DELAY constant.
- Sub-module `edge_detect`, one instance each for start and pause.
  - Single register with a parameterised reset value.
  - Output `rise` = in & ~q.

## Test plan
Run with SERVE_DELAY=4.
1. Reset held, then released while start=1 → no score_clear; state stays IDLE.
2. Start edge → score_clear high 1 cycle; SERVE for 4 cycles with paddle_en=1 and ball_en=0; then PLAY with ball_en=1 and serve_dir=1.
3. In PLAY, score_right pulse with game_over=0 → POINT for 2 cycles, serve_dir=0, then SERVE for 4 cycles, then PLAY.
4. score_left and score_right in the same cycle → serve_dir=1. With game_over=1 one cycle later → OVER; next start edge → score_clear pulse and SERVE.
5. With `GAME_CTRL_PAUSE_EN`: pause edge in PLAY → PAUSED with ball_en=0 and ball_reset=0; a score pulse there is ignored; second pause edge → PLAY. Without the macro: pause edges have no effect.
6. Reset asserted during SERVE with `cnt`=2 → IDLE immediately with all outputs at reset values.
